// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: requester indices,
// default widths and the hardwired-zero register address.
package rf_write_arbiter_pkg;

   localparam int REQ_WB = 0;
   localparam int REQ_MD = 1;
   localparam int REQ_LD = 2;

   localparam int AW_DEF = 5;
   localparam int DW_DEF = 32;

   localparam logic [AW_DEF-1:0] R0_ADDR = '0;

   // Round-robin successor over the low-priority indices 1..nreq-1.
   function automatic int rr_next(input int k, input int nreq);
      return (k >= nreq - 1) ? 1 : k + 1;
   endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_picker.sv
// Combinational round-robin pick over low-priority requesters 1..NREQ-1,
// starting the search at rr_ptr and wrapping back to 1.
module rf_rr_picker #(
   parameter int NREQ = 3,
   parameter int PW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:1] req_lo,
   input  logic [PW-1:0]   rr_ptr,
   output logic            pick_valid,
   output logic [PW-1:0]   pick_idx
);

   logic [PW-1:0] base;
   logic [PW-1:0] cand;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      // A zero pointer never occurs in operation; treat it as pointing at 1.
      base       = (rr_ptr == '0) ? '0 : rr_ptr - PW'(1);
      for (int off = 0; off < NREQ - 1; off++) begin
         cand = PW'(((int'(base) + off) % (NREQ - 1)) + 1);
         if (!pick_valid && req_lo[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: fixed priority for write-back with
// starvation relief for long-latency units, plus a pending-write scoreboard.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int DW      = DW_DEF,
   parameter int AW      = AW_DEF,
   parameter int MAXWAIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    gnt,
   input  logic               iss_valid,
   input  logic [AW-1:0]      iss_addr,
   output logic               iss_ready,
   input  logic [AW-1:0]      ra1,
   input  logic [AW-1:0]      ra2,
   output logic               hz1,
   output logic               hz2,
   output logic               rf_we,
   output logic [AW-1:0]      rf_wa,
   output logic [DW-1:0]      rf_wd,
   output logic [31:0]        pending
);

   localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
   localparam int WW = $clog2(MAXWAIT + 1);

   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic          rf_we_q, rf_we_d;
   logic [AW-1:0] rf_wa_q, rf_wa_d;
   logic [DW-1:0] rf_wd_q, rf_wd_d;
   logic [31:0]   pending_q, pending_d;

   logic          lo_req;
   logic          force_lo;
   logic          pick_valid;
   logic [PW-1:0] pick_idx;
   logic          win_any;
   logic [PW-1:0] win_idx;
   logic          lo_win;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_data;
   logic          iss_fire;

   rf_rr_picker #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_picker (
      .req_lo     (req[NREQ-1:1]),
      .rr_ptr     (rr_ptr_q),
      .pick_valid (pick_valid),
      .pick_idx   (pick_idx)
   );

   assign lo_req   = |req[NREQ-1:1];
   assign force_lo = (wait_cnt_q == WW'(MAXWAIT)) && lo_req;

   always_comb begin
      gnt     = '0;
      win_any = 1'b0;
      win_idx = '0;
      if (!rst) begin
         if (req[REQ_WB] && !force_lo) begin
            gnt[REQ_WB] = 1'b1;
            win_any     = 1'b1;
            win_idx     = PW'(REQ_WB);
         end else if (pick_valid) begin
            gnt[pick_idx] = 1'b1;
            win_any       = 1'b1;
            win_idx       = pick_idx;
         end
      end
   end

   assign lo_win = win_any && (win_idx != PW'(REQ_WB));

   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            win_addr = req_addr[i*AW +: AW];
            win_data = req_data[i*DW +: DW];
         end
      end
   end

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      wait_cnt_d = wait_cnt_q;
      rf_we_d    = 1'b0;
      rf_wa_d    = rf_wa_q;
      rf_wd_d    = rf_wd_q;

      if (lo_win) begin
         rr_ptr_d = PW'(rr_next(int'(win_idx), NREQ));
      end

      if (!lo_req || lo_win) begin
         wait_cnt_d = '0;
      end else if (win_any && wait_cnt_q != WW'(MAXWAIT)) begin
         wait_cnt_d = wait_cnt_q + WW'(1);
      end

      // r0 writes are consumed but never reach the register file.
      if (win_any) begin
         rf_we_d = (win_addr != AW'(R0_ADDR));
         rf_wa_d = win_addr;
         rf_wd_d = win_data;
      end
   end

   assign iss_ready = ~pending_q[iss_addr] | (rf_we_q && rf_wa_q == iss_addr);
   assign iss_fire  = iss_valid && iss_ready && (iss_addr != AW'(R0_ADDR));

   // Clear first, then set, so a same-cycle issue keeps the bit pending.
   always_comb begin
      pending_d = pending_q;
      if (rf_we_q) begin
         pending_d[rf_wa_q] = 1'b0;
      end
      if (iss_fire) begin
         pending_d[iss_addr] = 1'b1;
      end
   end

   assign hz1 = (ra1 != AW'(R0_ADDR)) && pending_q[ra1] && !(rf_we_q && rf_wa_q == ra1);
   assign hz2 = (ra2 != AW'(R0_ADDR)) && pending_q[ra2] && !(rf_we_q && rf_wa_q == ra2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= PW'(1);
         wait_cnt_q <= '0;
         rf_we_q    <= 1'b0;
         rf_wa_q    <= '0;
         rf_wd_q    <= '0;
         pending_q  <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         wait_cnt_q <= wait_cnt_d;
         rf_we_q    <= rf_we_d;
         rf_wa_q    <= rf_wa_d;
         rf_wd_q    <= rf_wd_d;
         pending_q  <= pending_d;
      end
   end

   assign rf_we   = rf_we_q;
   assign rf_wa   = rf_wa_q;
   assign rf_wd   = rf_wd_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;

   localparam int NREQ = 3;
   localparam int DW   = 32;
   localparam int AW   = 5;

   logic               clk;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic [AW-1:0]      addr [NREQ];
   logic [DW-1:0]      data [NREQ];
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt;
   logic               iss_valid;
   logic [AW-1:0]      iss_addr;
   logic               iss_ready;
   logic [AW-1:0]      ra1, ra2;
   logic               hz1, hz2;
   logic               rf_we;
   logic [AW-1:0]      rf_wa;
   logic [DW-1:0]      rf_wd;
   logic [31:0]        pending;

   int n_checks = 0;
   int n_errors = 0;

   assign req_addr = {addr[2], addr[1], addr[0]};
   assign req_data = {data[2], data[1], data[0]};

   rf_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .MAXWAIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .gnt       (gnt),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .iss_ready (iss_ready),
      .ra1       (ra1),
      .ra2       (ra2),
      .hz1       (hz1),
      .hz2       (hz2),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   logic [NREQ-1:0] starve_exp [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};
   logic [NREQ-1:0] rr_exp     [4] = '{3'b010, 3'b100, 3'b010, 3'b100};

   initial begin
      rst = 1'b1;
      req = '0;
      iss_valid = 1'b0;
      iss_addr = '0;
      ra1 = '0;
      ra2 = '0;
      for (int i = 0; i < NREQ; i++) begin
         addr[i] = '0;
         data[i] = '0;
      end
      #3;
      chk("reset_gnt", gnt, 0);
      chk("reset_we", rf_we, 0);
      chk("reset_pending", pending, 0);
      cycle();
      rst = 1'b0;

      // single write from requester 1
      req = 3'b010; addr[1] = 5'd7; data[1] = 32'hDEADBEEF;
      #1;
      chk("single_gnt", gnt, 3'b010);
      cycle();
      req = '0;
      chk("single_we", rf_we, 1);
      chk("single_wa", rf_wa, 7);
      chk("single_wd", rf_wd, 32'hDEADBEEF);

      // starvation relief: req0 and req2 held
      req = 3'b101; addr[0] = 5'd3; data[0] = 32'h11; addr[2] = 5'd4; data[2] = 32'h22;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk($sformatf("starve_gnt%0d", c), gnt, starve_exp[c]);
         cycle();
      end
      req = '0;
      cycle();

      // round robin between requesters 1 and 2, pointer back at 1
      req = 3'b110; addr[1] = 5'd10; addr[2] = 5'd11;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("rr_gnt%0d", c), gnt, rr_exp[c]);
         cycle();
      end
      req = '0;
      cycle();

      // scoreboard and hazard on r9
      iss_valid = 1'b1; iss_addr = 5'd9;
      #1;
      chk("iss9_ready_first", iss_ready, 1);
      cycle();
      chk("pending9_set", pending, 32'h0000_0200);
      chk("iss9_ready_second", iss_ready, 0);
      cycle();
      iss_valid = 1'b0;
      ra1 = 5'd9; ra2 = 5'd9;
      #1;
      chk("hz1_r9", hz1, 1);
      chk("hz2_r9", hz2, 1);
      req = 3'b010; addr[1] = 5'd9; data[1] = 32'h1234;
      #1;
      chk("r9_write_gnt", gnt, 3'b010);
      cycle();
      req = '0;
      #1;
      chk("r9_we", rf_we, 1);
      chk("r9_wa", rf_wa, 9);
      chk("hz1_drop", hz1, 0);
      chk("pending9_still", pending[9], 1);
      cycle();
      chk("pending9_clear", pending, 0);
      chk("hz1_after", hz1, 0);
      ra1 = '0; ra2 = '0;

      // write to r0
      req = 3'b010; addr[1] = 5'd0; data[1] = 32'h55;
      #1;
      chk("r0_gnt", gnt, 3'b010);
      cycle();
      req = '0;
      chk("r0_we", rf_we, 0);
      chk("r0_pending", pending, 0);

      // same-cycle clear and set on r5
      iss_valid = 1'b1; iss_addr = 5'd5;
      cycle();
      iss_valid = 1'b0;
      chk("pending5_set", pending, 32'h0000_0020);
      req = 3'b010; addr[1] = 5'd5; data[1] = 32'h77;
      cycle();
      req = '0;
      chk("r5_we", rf_we, 1);
      iss_valid = 1'b1; iss_addr = 5'd5;
      #1;
      chk("r5_iss_ready", iss_ready, 1);
      cycle();
      iss_valid = 1'b0;
      chk("pending5_kept", pending, 32'h0000_0020);
      cycle();
      chk("pending5_kept2", pending, 32'h0000_0020);

      // reset mid-operation with a write in flight
      req = 3'b010; addr[1] = 5'd3; data[1] = 32'hAA;
      cycle();
      req = 3'b001;
      chk("pre_rst_we", rf_we, 1);
      rst = 1'b1;
      #1;
      chk("midrst_we", rf_we, 0);
      chk("midrst_wa", rf_wa, 0);
      chk("midrst_wd", rf_wd, 0);
      chk("midrst_pending", pending, 0);
      chk("midrst_gnt", gnt, 0);
      cycle();
      rst = 1'b0;
      req = 3'b110;
      #1;
      chk("post_rst_rr", gnt, 3'b010);
      cycle();
      req = '0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
